// File: rtl/usb_packet_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : USBPkg
//  Description : Shared types, CRC constants and helper functions for the
//                bit-serial USB packet receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package USBPkg;

    // Line state as {dp, dm}
    typedef enum logic [1:0] {
        BUS_SE0 = 2'b00,
        BUS_K   = 2'b01,
        BUS_J   = 2'b10,
        BUS_SE1 = 2'b11
    } bus_state_t;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_SYNC  = 3'd1,
        ERR_PID   = 3'd2,
        ERR_STUFF = 3'd3,
        ERR_CRC5  = 3'd4,
        ERR_CRC16 = 3'd5,
        ERR_LEN   = 3'd6,
        ERR_SE1   = 3'd7
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_PID   = 3'd2,
        ST_TOKEN = 3'd3,
        ST_DATA  = 3'd4,
        ST_EOP1  = 3'd5,
        ST_EOP2  = 3'd6,
        ST_DRAIN = 3'd7
    } rx_state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_INIT      = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // One serial CRC5 step; feedback taken from the MSB
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[4];
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b0);
    endfunction

    // One serial CRC16 step; feedback taken from the MSB
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'b0);
    endfunction

    function automatic logic pid_is_known(input logic [3:0] nib);
        case (nib)
            PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_packet_receiver_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
//  Module      : usb_nrzi_unstuff
//  Description : NRZI decoder and bit unstuffer. Classifies the line state,
//                decodes J/K samples into bits and flags the stuffed bit that
//                follows six consecutive ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_nrzi_unstuff
    import USBPkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic dp,
    input  logic dm,
    input  logic force_j,    // treat previous level as J (receiver idle)
    input  logic clr_ones,   // restart the run-of-ones count
    output logic rx_bit,
    output logic bit_valid,  // low on stuffed bits and on SE0/SE1
    output logic se0,
    output logic se1,
    output logic stuff_err
);

    bus_state_t line;
    logic       jk;
    logic       prev_j;
    logic       stuffed;
    logic       prev_j_q, prev_j_d;
    logic [2:0] ones_q, ones_d;

    // Decode the current sample and work out the next previous-level / run count
    always_comb begin
        line      = bus_state_t'({dp, dm});
        se0       = (line == BUS_SE0);
        se1       = (line == BUS_SE1);
        jk        = !se0 && !se1;
        prev_j    = force_j | prev_j_q;
        rx_bit    = jk && ((line == BUS_J) == prev_j);
        stuffed   = jk && (ones_q == 3'd6);
        bit_valid = jk && !stuffed;
        stuff_err = stuffed && rx_bit;
        prev_j_d  = jk ? (line == BUS_J) : prev_j;
        ones_d    = ones_q;
        if (clr_ones || stuffed) begin
            ones_d = 3'd0;
        end else if (jk) begin
            ones_d = rx_bit ? ones_q + 3'd1 : 3'd0;
        end
    end

    // Previous line level and run-of-ones register
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_j_q <= 1'b1;
            ones_q   <= 3'd0;
        end else begin
            prev_j_q <= prev_j_d;
            ones_q   <= ones_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : usb_packet_receiver
//  Description : Bit-serial USB packet receiver. Frames SYNC/PID/fields/EOP,
//                checks PID, CRC5 and CRC16, and presents decoded fields with
//                a one-cycle valid or error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_packet_receiver
    import USBPkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        dp,
    input  logic        dm,
    output logic        pkt_valid,
    output logic        pkt_error,
    output logic [2:0]  err_code,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        busy
);

    logic rx_bit, bit_valid, se0, se1, stuff_err;
    logic line_j;

    rx_state_t   state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  pid_sr_q, pid_sr_d;
    logic [10:0] tok_q, tok_d;
    logic [63:0] pay_q, pay_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [3:0]  rx_pid_q, rx_pid_d;
    logic        se0_seen_q, se0_seen_d;

    logic        pkt_valid_q, pkt_valid_d;
    logic        pkt_error_q, pkt_error_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [63:0] data_q, data_d;
    logic        busy_q, busy_d;

    logic        fail;
    err_code_t   fail_code;
    logic [7:0]  pid_byte;
    logic [4:0]  crc5_nx;
    logic [15:0] crc16_nx;

    assign line_j = dp & ~dm;

    usb_nrzi_unstuff u_nrzi (
        .clock     (clock),
        .reset     (reset),
        .dp        (dp),
        .dm        (dm),
        .force_j   (state_q == ST_IDLE),
        .clr_ones  ((state_q == ST_IDLE) || (state_q == ST_SYNC) ||
                    (state_q == ST_EOP2) || (state_q == ST_DRAIN)),
        .rx_bit    (rx_bit),
        .bit_valid (bit_valid),
        .se0       (se0),
        .se1       (se1),
        .stuff_err (stuff_err)
    );

    // Packet framing FSM: next state, field capture, CRC and output pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pid_sr_d    = pid_sr_q;
        tok_d       = tok_q;
        pay_d       = pay_q;
        crc5_d      = crc5_q;
        crc16_d     = crc16_q;
        rx_pid_d    = rx_pid_q;
        se0_seen_d  = se0_seen_q;
        pkt_valid_d = 1'b0;
        pkt_error_d = 1'b0;
        err_code_d  = err_code_q;
        pid_d       = pid_q;
        addr_d      = addr_q;
        endp_d      = endp_q;
        data_d      = data_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
        pid_byte    = {rx_bit, pid_sr_q};
        crc5_nx     = crc5_step(crc5_q, rx_bit);
        crc16_nx    = crc16_step(crc16_q, rx_bit);

        case (state_q)
            ST_IDLE: begin
                // The first K decodes to 0 and is SYNC bit 0
                if (bit_valid && !rx_bit) begin
                    state_d = ST_SYNC;
                    cnt_d   = 7'd1;
                end
            end
            ST_SYNC: begin
                if (se1) begin
                    fail = 1'b1; fail_code = ERR_SE1;
                end else if (se0) begin
                    fail = 1'b1; fail_code = ERR_SYNC;
                end else if (bit_valid) begin
                    if (rx_bit != (cnt_q == 7'd7)) begin
                        fail = 1'b1; fail_code = ERR_SYNC;
                    end else if (cnt_q == 7'd7) begin
                        state_d = ST_PID;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_PID: begin
                if (se1) begin
                    fail = 1'b1; fail_code = ERR_SE1;
                end else if (stuff_err) begin
                    fail = 1'b1; fail_code = ERR_STUFF;
                end else if (se0) begin
                    fail = 1'b1; fail_code = ERR_LEN;
                end else if (bit_valid) begin
                    if (cnt_q == 7'd7) begin
                        if ((pid_byte[7:4] != ~pid_byte[3:0]) || !pid_is_known(pid_byte[3:0])) begin
                            fail = 1'b1; fail_code = ERR_PID;
                        end else begin
                            rx_pid_d = pid_byte[3:0];
                            cnt_d    = 7'd0;
                            crc5_d   = CRC5_INIT;
                            crc16_d  = CRC16_INIT;
                            case (pid_byte[3:0])
                                PID_OUT, PID_IN:     state_d = ST_TOKEN;
                                PID_DATA0, PID_DATA1: state_d = ST_DATA;
                                default:             state_d = ST_EOP1;
                            endcase
                        end
                    end else begin
                        pid_sr_d = {rx_bit, pid_sr_q[6:1]};
                        cnt_d    = cnt_q + 7'd1;
                    end
                end
            end
            ST_TOKEN: begin
                if (se1) begin
                    fail = 1'b1; fail_code = ERR_SE1;
                end else if (stuff_err) begin
                    fail = 1'b1; fail_code = ERR_STUFF;
                end else if (se0) begin
                    fail = 1'b1; fail_code = ERR_LEN;
                end else if (bit_valid) begin
                    crc5_d = crc5_nx;
                    if (cnt_q < 7'd11) begin
                        tok_d = {rx_bit, tok_q[10:1]};
                    end
                    if (cnt_q == 7'd15) begin
                        if (crc5_nx != CRC5_RESIDUAL) begin
                            fail = 1'b1; fail_code = ERR_CRC5;
                        end else begin
                            state_d = ST_EOP1;
                        end
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_DATA: begin
                if (se1) begin
                    fail = 1'b1; fail_code = ERR_SE1;
                end else if (stuff_err) begin
                    fail = 1'b1; fail_code = ERR_STUFF;
                end else if (se0) begin
                    fail = 1'b1; fail_code = ERR_LEN;
                end else if (bit_valid) begin
                    crc16_d = crc16_nx;
                    if (cnt_q < 7'd64) begin
                        pay_d = {rx_bit, pay_q[63:1]};
                    end
                    if (cnt_q == 7'd79) begin
                        if (crc16_nx != CRC16_RESIDUAL) begin
                            fail = 1'b1; fail_code = ERR_CRC16;
                        end else begin
                            state_d = ST_EOP1;
                        end
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_EOP1: begin
                // A stuffed bit may still trail the last field bit here
                if (se1) begin
                    fail = 1'b1; fail_code = ERR_SE1;
                end else if (stuff_err) begin
                    fail = 1'b1; fail_code = ERR_STUFF;
                end else if (se0) begin
                    state_d    = ST_EOP2;
                    se0_seen_d = 1'b0;
                end else if (bit_valid) begin
                    fail = 1'b1; fail_code = ERR_LEN;
                end
            end
            ST_EOP2: begin
                // se0_seen marks the second SE0; J after it closes the packet
                if (se1) begin
                    fail = 1'b1; fail_code = ERR_SE1;
                end else if (se0) begin
                    if (se0_seen_q) begin
                        fail = 1'b1; fail_code = ERR_LEN;
                    end else begin
                        se0_seen_d = 1'b1;
                    end
                end else if (line_j && se0_seen_q) begin
                    state_d     = ST_IDLE;
                    pkt_valid_d = 1'b1;
                    err_code_d  = ERR_NONE;
                    pid_d       = rx_pid_q;
                    case (rx_pid_q)
                        PID_OUT, PID_IN: begin
                            addr_d = tok_q[6:0];
                            endp_d = tok_q[10:7];
                        end
                        PID_DATA0, PID_DATA1: data_d = pay_q;
                        default: ;
                    endcase
                end else begin
                    fail = 1'b1; fail_code = ERR_LEN;
                end
            end
            ST_DRAIN: begin
                // Ignore the bus until an SE0 is followed by J
                if (se0) begin
                    se0_seen_d = 1'b1;
                end else if (line_j && se0_seen_q) begin
                    state_d = ST_IDLE;
                end else begin
                    se0_seen_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            state_d     = ST_DRAIN;
            pkt_error_d = 1'b1;
            err_code_d  = fail_code;
            se0_seen_d  = se0;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DRAIN);
    end

    // State, working registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 7'd0;
            pid_sr_q    <= 7'd0;
            tok_q       <= 11'd0;
            pay_q       <= 64'd0;
            crc5_q      <= CRC5_INIT;
            crc16_q     <= CRC16_INIT;
            rx_pid_q    <= 4'd0;
            se0_seen_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_error_q <= 1'b0;
            err_code_q  <= 3'd0;
            pid_q       <= 4'd0;
            addr_q      <= 7'd0;
            endp_q      <= 4'd0;
            data_q      <= 64'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pid_sr_q    <= pid_sr_d;
            tok_q       <= tok_d;
            pay_q       <= pay_d;
            crc5_q      <= crc5_d;
            crc16_q     <= crc16_d;
            rx_pid_q    <= rx_pid_d;
            se0_seen_q  <= se0_seen_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_error_q <= pkt_error_d;
            err_code_q  <= err_code_d;
            pid_q       <= pid_d;
            addr_q      <= addr_d;
            endp_q      <= endp_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_error = pkt_error_q;
    assign err_code  = err_code_q;
    assign pid       = pid_q;
    assign addr      = addr_q;
    assign endp      = endp_q;
    assign data      = data_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
